// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Converts a binary value to BCD with a sequential double-dabble engine
//   (one input bit per clock) and time-multiplexes the latched result onto
//   active-low seven-segment digits. Leading-zero blanking is optional.
//   Overflow (result wider than DIGITS decimal digits) shows dashes.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for load; result registers hold the last value
//   SHIFT | double-dabble running, one bit per cycle, BIN_W cycles
//
// Ports
//   clk          system clock, posedge
//   rst          synchronous active-high reset
//   bin_in       binary value, sampled when a load is accepted
//   load         start conversion (ignored while busy)
//   busy         conversion in progress
//   done         one-cycle pulse, bcd_out/ovf just updated
//   bcd_out      latched BCD result, digit 0 in bits [3:0]
//   ovf          latched overflow flag
//   seg_cathode  active-low segments, bit0=a .. bit6=g
//   seg_anode_o  active-low one-hot digit enable, bit0 = rightmost digit
module bcd_scan_display #(
  parameter int BIN_W       = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [6:0]            seg_cathode,
  output logic [DIGITS-1:0]     seg_anode_o
);

  // Scratch holds enough BCD digits for the full input range so the
  // conversion itself never truncates; extra digits only feed ovf.
  localparam int MIN_DIG = (BIN_W + 2) / 3;
  localparam int INT_DIG = (DIGITS > MIN_DIG) ? DIGITS : MIN_DIG;
  localparam int SW      = INT_DIG * 4;
  localparam int CW      = $clog2(BIN_W + 1);
  localparam int RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic              start, finish;

  logic [BIN_W-1:0]  shreg;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adj;
  logic [SW-1:0]     shifted;
  logic [CW-1:0]     bit_cnt;
  logic              upper_nz;

  logic              done_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic              ovf_r;

  logic [RW-1:0]     ref_cnt;
  logic [IW-1:0]     scan_idx, idx_nxt;
  logic              ref_wrap;
  logic [DIGITS-1:0] lz_zero;
  logic [3:0]        sel_nib;
  logic [6:0]        cath_nxt;
  logic [6:0]        cath_r;
  logic [DIGITS-1:0] anode_r;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs / datapath controls
  always_comb begin
    busy   = (state == SHIFT);
    start  = (state == IDLE) && load;
    finish = (state == SHIFT) && (bit_cnt == CW'(1));
  end

  // ---------------------------------------------------------------
  // Double-dabble step: add-3 correction then shift in next MSB
  // ---------------------------------------------------------------
  always_comb begin
    adj = '0;
    for (int i = 0; i < INT_DIG; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      else                           adj[i*4 +: 4] = scratch[i*4 +: 4];
    end
    shifted = {adj[SW-2:0], shreg[BIN_W-1]};
  end

  // Digits above DIGITS only exist when the input range needs them.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = DIGITS; i < INT_DIG; i++) begin
      upper_nz = upper_nz | (|shifted[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        shreg   <= bin_in;
        scratch <= '0;
        bit_cnt <= CW'(BIN_W);
      end else if (busy) begin
        scratch <= shifted;
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - CW'(1);
        if (finish) begin
          bcd_r  <= shifted[4*DIGITS-1:0];
          ovf_r  <= upper_nz;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign done    = done_r;
  assign bcd_out = bcd_r;
  assign ovf     = ovf_r;

  // ---------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------
  always_comb begin
    ref_wrap = (ref_cnt == RW'(REFRESH_DIV - 1));
    if (scan_idx == IW'(DIGITS - 1)) idx_nxt = '0;
    else                             idx_nxt = scan_idx + IW'(1);
  end

  // lz_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic acc;
    acc     = 1'b1;
    lz_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc        = acc & (bcd_r[i*4 +: 4] == 4'd0);
      lz_zero[i] = acc;
    end
  end

  always_comb begin
    sel_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IW'(i)) sel_nib = bcd_r[i*4 +: 4];
    end
  end

  // Cathodes are computed for the digit about to be enabled so anode and
  // cathode registers update on the same edge without a glitch.
  always_comb begin
    if (ovf_r)
      cath_nxt = SEG_DASH;
    else if ((BLANK_LZ != 0) && (idx_nxt != '0) && lz_zero[idx_nxt])
      cath_nxt = SEG_OFF;
    else
      cath_nxt = seg_decode(sel_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
      anode_r  <= ~DIGITS'(1);
      cath_r   <= SEG_ZERO;
    end else if (ref_wrap) begin
      ref_cnt  <= '0;
      scan_idx <= idx_nxt;
      anode_r  <= ~(DIGITS'(1) << idx_nxt);
      cath_r   <= cath_nxt;
    end else begin
      ref_cnt  <= ref_cnt + RW'(1);
    end
  end

  assign seg_anode_o = anode_r;
  assign seg_cathode = cath_r;

endmodule
